// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} bcd_state_t;

    localparam int BCD_DIGIT_W = 4;

    // Number of decimal digits needed to print the largest unsigned value of 'width' bits.
    function automatic int digits_needed(input int width);
        longint unsigned max_val;
        int              n;
        max_val = (64'd1 << width) - 64'd1;
        n       = 1;
        for (int i = 0; i < 20; i++) begin
            if (max_val >= 64'd10) begin
                max_val = max_val / 64'd10;
                n       = n + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single BCD digit pre-shift correction: digits of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_d,
    output logic [BCD_DIGIT_W-1:0] o_d
);

    assign o_d = (i_d >= BCD_DIGIT_W'(5)) ? (i_d + BCD_DIGIT_W'(3)) : i_d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one input bit per clock, result held in
// registers with a valid/ready handshake and a significant-digit count.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter  int IN_W   = 9,
    parameter  int DIGITS = 3,
    localparam int NDIG_W = $clog2(DIGITS + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_W-1:0]               in_bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
    output logic [NDIG_W-1:0]             out_ndig,
    output logic                          busy
);

    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;

    // The digit count must be able to hold the largest input value.
    if (DIGITS < digits_needed(IN_W)) begin : g_digits_check
        $error("bin2bcd_seq: DIGITS too small to represent 2**IN_W-1");
    end

    bcd_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IN_W-1:0]  r_bin_sr;
    logic [BCD_W-1:0] r_bcd_sr;
    logic [BCD_W-1:0] r_out_bcd;
    logic [NDIG_W-1:0] r_out_ndig;

    logic [BCD_W-1:0] w_adj;
    logic [BCD_W-1:0] w_bcd_shift;
    logic [IN_W-1:0]  w_bin_shift;
    logic [NDIG_W-1:0] w_ndig;

    // Per-digit +3 correction applied before every shift.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
        bcd_add3 u_add3 (
            .i_d (r_bcd_sr[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_d (w_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // One-bit left shift of the corrected {bcd, bin} pair; the top corrected
    // bit would fall off and is checked to be zero below.
    assign w_bcd_shift = {w_adj[BCD_W-2:0], r_bin_sr[IN_W-1]};
    assign w_bin_shift = {r_bin_sr[IN_W-2:0], 1'b0};

    // Significant-digit count of the final shift result: highest nonzero digit wins, zero reads as one digit.
    always_comb begin
        w_ndig = NDIG_W'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (w_bcd_shift[i*BCD_DIGIT_W +: BCD_DIGIT_W] != '0) begin
                w_ndig = NDIG_W'(i + 1);
            end
        end
    end

    // Conversion FSM: load in IDLE, IN_W correction+shift steps, hold the result until consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bin_sr   <= '0;
            r_bcd_sr   <= '0;
            r_out_bcd  <= '0;
            r_out_ndig <= NDIG_W'(1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_bin_sr <= in_bin;
                        r_bcd_sr <= '0;
                        r_cnt    <= CNT_W'(IN_W);
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bcd_sr <= w_bcd_shift;
                    r_bin_sr <= w_bin_shift;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_out_bcd  <= w_bcd_shift;
                        r_out_ndig <= w_ndig;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Digit sanity: no digit above 9 and no corrected bit lost off the top while shifting.
    always_ff @(posedge clk) begin
        if (rst_n && r_state == S_SHIFT) begin
            assert (!w_adj[BCD_W-1]);
            for (int i = 0; i < DIGITS; i++) begin
                assert (r_bcd_sr[i*BCD_DIGIT_W +: BCD_DIGIT_W] <= BCD_DIGIT_W'(9));
            end
        end
    end

    assign in_ready  = rst_n && (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_bcd   = r_out_bcd;
    assign out_ndig  = r_out_ndig;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: directed cases plus a full 0..511 sweep
// with random consumer back-pressure, checked against a decimal-string model.
module tb_bin2bcd_seq;

    localparam int IN_W   = 9;
    localparam int DIGITS = 3;
    localparam int NDIG_W = 2;
    localparam int PERIOD = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IN_W-1:0]   in_bin = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [4*DIGITS-1:0] out_bcd;
    logic [NDIG_W-1:0] out_ndig;
    logic              busy;

    typedef struct {
        logic [11:0] bcd;
        int          ndig;
        longint      t_acc;
    } exp_t;

    exp_t   sb[$];
    int     n_pass = 0;
    int     n_total = 0;
    bit     rand_ready = 1'b0;
    longint t_last_hs = 0;
    longint t_last_acc = 0;

    bin2bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_ndig  (out_ndig),
        .busy      (busy)
    );

    always #(PERIOD/2) clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: print the value in decimal and read the characters back as BCD nibbles.
    function automatic exp_t model(input int v);
        exp_t  e;
        string s;
        s      = $sformatf("%0d", v);
        e.bcd  = '0;
        for (int i = 0; i < s.len(); i++) begin
            e.bcd = (e.bcd << 4) | 12'(s[i] - 8'd48);
        end
        e.ndig  = s.len();
        e.t_acc = 0;
        return e;
    endfunction

    // Offer v until accepted; optionally keep in_valid high afterwards and/or expect a result.
    task automatic send(input int v, input bit keep, input bit expect_out);
        exp_t e;
        int   waited;
        waited   = 0;
        in_bin   = IN_W'(v);
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        t_last_acc = $time;
        if (expect_out) begin
            e       = model(v);
            e.t_acc = $time;
            sb.push_back(e);
        end
        #1;
        if (!keep) in_valid = 1'b0;
        in_bin = IN_W'($urandom);
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        forever begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready) break;
            waited++;
            if (waited > 3000) begin
                check("idle_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: latency on each rising out_valid, data on each handshake.
    initial begin
        exp_t e;
        bit   prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (out_valid && !prev) begin
                    if (sb.size() == 0) check("spurious_out_valid", 1, 0);
                    else check("latency", $time - sb[0].t_acc, IN_W*PERIOD + PERIOD/2);
                end
                if (out_valid && out_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    check("out_bcd", out_bcd, e.bcd);
                    check("out_ndig", out_ndig, e.ndig);
                    $display("out 0x%03h ndig %0d", out_bcd, out_ndig);
                    t_last_hs = $time + PERIOD/2;
                end
                prev = out_valid;
            end
        end
    end

    // Random consumer back-pressure, active only during the sweep.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bcd", out_bcd, 0);
        check("rst_out_ndig", out_ndig, 1);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;

        // Zero, then the extremes
        out_ready = 1'b1;
        send(0, 0, 1);   wait_idle();
        send(511, 0, 1); wait_idle();
        send(255, 0, 1); wait_idle();

        // Held result under back-pressure
        out_ready = 1'b0;
        send(137, 0, 1);
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_bcd", out_bcd, 12'h137);
            check("hold_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle();

        // Back-to-back with in_valid held: one bubble after the handshake
        send(9, 1, 1);
        send(10, 0, 1);
        check("b2b_accept_gap", t_last_acc - t_last_hs, PERIOD);
        wait_idle();

        // Reset at the 4th shift edge abandons the conversion
        send(300, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_bcd", out_bcd, 0);
        repeat (15) @(negedge clk);
        check("abort_no_output", out_valid, 0);
        @(posedge clk);
        #1;
        send(42, 0, 1);
        wait_idle();

        // Full sweep with random gaps and random out_ready
        rand_ready = 1'b1;
        for (int v = 0; v < (1 << IN_W); v++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(v, 0, 1);
        end
        wait_idle();
        rand_ready = 1'b0;

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
